// File: rtl/mod17_residue_checker.sv
// Receive-side mod-17 residue checker: recomputes divident mod 17 one nibble per
// cycle (MSB first), compares against the received residue and counts mismatches.
module mod17_residue_checker #(
  parameter int DATA_W    = 32,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mark_in,
  input  logic [DATA_W-1:0]    divident,
  input  logic [4:0]           reminder_in,
  input  logic                 clr_cnt,
  output logic                 ready,
  output logic                 mark_out,
  output logic [4:0]           reminder_calc,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 overrun
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic [4:0]          rin_reg, rin_next;
  logic [4:0]          acc_reg, acc_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                accept;
  logic                err_now;

  // One Horner step: acc*16 + nib (mod 17), using 16 == -1 so only a negate-and-add is needed.
  function automatic logic [4:0] step_f(input logic [4:0] acc, input logic [3:0] nib);
    logic [4:0] neg;
    logic [5:0] t;
    logic [5:0] r;
    neg = (acc == 5'd0) ? 5'd0 : (5'd17 - acc);
    t   = {1'b0, neg} + {2'b00, nib};
    r   = (t >= 6'd17) ? (t - 6'd17) : t;
    return r[4:0];
  endfunction

  assign ready   = (state_reg != CALC);
  assign accept  = mark_in && (state_reg != CALC);
  assign err_now = (rin_reg > 5'd16) || (rin_reg != acc_reg);

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    rin_next   = rin_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = CALC;
          data_next  = divident;
          rin_next   = reminder_in;
          acc_next   = 5'd0;
          cnt_next   = '0;
        end
      end
      CALC: begin
        acc_next  = step_f(acc_reg, data_reg[DATA_W-1 -: 4]);
        data_next = data_reg << 4;
        cnt_next  = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(NIB - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // A word accepted here starts immediately; the old result is still emitted below.
        if (accept) begin
          state_next = CALC;
          data_next  = divident;
          rin_next   = reminder_in;
          acc_next   = 5'd0;
          cnt_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      rin_reg   <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      rin_reg   <= rin_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mark_out      <= 1'b0;
      reminder_calc <= 5'd0;
      err           <= 1'b0;
    end else begin
      mark_out <= (state_reg == DONE);
      if (state_reg == DONE) begin
        reminder_calc <= acc_reg;
        err           <= err_now;
      end
    end
  end

  // Counter moves together with mark_out so err_cnt already includes the word being reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if ((state_reg == DONE) && err_now && !(&err_cnt)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (mark_in && !ready) begin
      overrun <= 1'b1;
    end else if (clr_cnt) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod17_residue_checker.sv
// Bench for mod17_residue_checker: directed corner cases plus randomized back-to-back
// traffic checked against an arithmetic (divident % 17) reference model.
module tb_mod17_residue_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mark_in = 1'b0;
  logic [31:0] divident = '0;
  logic [4:0]  reminder_in = '0;
  logic        clr_cnt = 1'b0;

  logic        ready, mark_out, err, overrun;
  logic [4:0]  reminder_calc;
  logic [15:0] err_cnt;

  logic        ready2, mark_out2, err2, overrun2;
  logic [4:0]  reminder_calc2;
  logic [1:0]  err_cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  int exp_cnt2 = 0;

  always #5 clk = ~clk;

  mod17_residue_checker #(.DATA_W(32), .ERR_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mark_in(mark_in), .divident(divident),
    .reminder_in(reminder_in), .clr_cnt(clr_cnt), .ready(ready), .mark_out(mark_out),
    .reminder_calc(reminder_calc), .err(err), .err_cnt(err_cnt), .overrun(overrun)
  );

  mod17_residue_checker #(.DATA_W(32), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mark_in(mark_in), .divident(divident),
    .reminder_in(reminder_in), .clr_cnt(clr_cnt), .ready(ready2), .mark_out(mark_out2),
    .reminder_calc(reminder_calc2), .err(err2), .err_cnt(err_cnt2), .overrun(overrun2)
  );

  function automatic int model_rem(input logic [31:0] d);
    longint unsigned v;
    v = longint'(d);
    return int'(v % 17);
  endfunction

  function automatic bit model_err(input logic [31:0] d, input logic [4:0] r);
    return (int'(r) > 16) || (int'(r) != model_rem(d));
  endfunction

  task automatic note_err_word(input bit e);
    if (e) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
  endtask

  // Drives one word from IDLE and waits (bounded) for its result.
  task automatic run_word(input logic [31:0] d, input logic [4:0] r,
                          output logic [4:0] calc, output logic e, output int lat);
    mark_in = 1'b1; divident = d; reminder_in = r;
    @(posedge clk); #1;
    mark_in = 1'b0;
    lat = -1; calc = '0; e = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (mark_out) begin
        lat = n; calc = reminder_calc; e = err;
        break;
      end
    end
  endtask

  task automatic do_clr();
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    exp_cnt = 0; exp_cnt2 = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ready, mark_out, reminder_calc, err, err_cnt, overrun} !== {1'b1, 1'b0, 5'd0, 1'b0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%0b mark_out=%0b calc=%0d err=%0b cnt=%0d ovr=%0b expected 1 0 0 0 0 0",
               ready, mark_out, reminder_calc, err, err_cnt, overrun);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_cnt = 0; exp_cnt2 = 0;
  endtask

  task automatic test_directed();
    logic [31:0] dv [4] = '{32'h12345678, 32'hFFFFFFFF, 32'h00000010, 32'h00000011};
    logic [4:0]  rv [4] = '{5'd4, 5'd0, 5'd16, 5'd1};
    logic [4:0] calc; logic e; int lat; bit exp_e;
    for (int i = 0; i < 4; i++) begin
      run_word(dv[i], rv[i], calc, e, lat);
      exp_e = model_err(dv[i], rv[i]);
      note_err_word(exp_e);
      n_checks++;
      if (lat != 9) begin
        n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected 9", i, lat);
      end
      n_checks++;
      if ({calc, e} !== {5'(model_rem(dv[i])), exp_e}) begin
        n_fail++; $display("FAIL directed_result[%0d]: got calc=%0d err=%0b expected calc=%0d err=%0b",
                           i, calc, e, model_rem(dv[i]), exp_e);
      end
      n_checks++;
      if (int'(err_cnt) != exp_cnt) begin
        n_fail++; $display("FAIL directed_err_cnt[%0d]: got %0d expected %0d", i, err_cnt, exp_cnt);
      end
      $display("directed word %08h rin=%0d -> calc=%0d err=%0b lat=%0d", dv[i], rv[i], calc, e, lat);
    end
  endtask

  task automatic test_illegal_rin();
    logic [4:0] calc; logic e; int lat;
    run_word(32'h00000011, 5'd17, calc, e, lat);
    note_err_word(1'b1);
    n_checks++;
    if ({calc, e} !== {5'd0, 1'b1} || lat != 9) begin
      n_fail++; $display("FAIL illegal_rin: got calc=%0d err=%0b lat=%0d expected calc=0 err=1 lat=9", calc, e, lat);
    end
    $display("illegal rin=17 on 00000011 -> calc=%0d err=%0b", calc, e);
  endtask

  task automatic test_overrun();
    int marks = 0;
    logic [4:0] calc = '0; logic e = 1'b0;
    do_clr();
    divident = 32'h00000011; reminder_in = 5'd1;
    mark_in = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      divident = 32'h12345678; reminder_in = 5'd4;
    end
    mark_in = 1'b0;
    for (int n = 0; n < 15; n++) begin
      if (mark_out) begin marks++; calc = reminder_calc; e = err; end
      @(posedge clk); #1;
    end
    note_err_word(1'b1);
    n_checks++;
    if (marks != 1 || calc !== 5'd0 || e !== 1'b1) begin
      n_fail++; $display("FAIL overrun_single_word: got marks=%0d calc=%0d err=%0b expected 1 0 1", marks, calc, e);
    end
    n_checks++;
    if (overrun !== 1'b1 || int'(err_cnt) != exp_cnt) begin
      n_fail++; $display("FAIL overrun_flag: got ovr=%0b cnt=%0d expected 1 %0d", overrun, err_cnt, exp_cnt);
    end
    do_clr();
    n_checks++;
    if (overrun !== 1'b0 || err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL overrun_clear: got ovr=%0b cnt=%0d expected 0 0", overrun, err_cnt);
    end
    // New overrun in the same cycle as clr_cnt must win.
    mark_in = 1'b1; divident = 32'h12345678; reminder_in = 5'd4;
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0; mark_in = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_vs_clr: got %0b expected 1", overrun);
    end
    repeat (12) @(posedge clk);
    #1;
    do_clr();
    $display("overrun test: marks=%0d ovr_after_clr=%0b", marks, overrun);
  endtask

  task automatic test_reset_mid_calc();
    int marks = 0;
    logic [4:0] calc; logic e; int lat;
    mark_in = 1'b1; divident = 32'hDEADBEEF; reminder_in = 5'd3;
    @(posedge clk); #1;
    mark_in = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready, mark_out, reminder_calc, err, err_cnt, overrun} !== {1'b1, 1'b0, 5'd0, 1'b0, 16'd0, 1'b0}) begin
      n_fail++; $display("FAIL midcalc_reset_outputs: got ready=%0b mark_out=%0b calc=%0d err=%0b cnt=%0d ovr=%0b",
                         ready, mark_out, reminder_calc, err, err_cnt, overrun);
    end
    #2 rst_n = 1'b1;
    exp_cnt = 0; exp_cnt2 = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (mark_out) marks++;
    end
    n_checks++;
    if (marks != 0) begin
      n_fail++; $display("FAIL midcalc_no_mark_out: got %0d strobes expected 0", marks);
    end
    run_word(32'hCAFEF00D, 5'(model_rem(32'hCAFEF00D)), calc, e, lat);
    n_checks++;
    if (calc !== 5'(model_rem(32'hCAFEF00D)) || e !== 1'b0 || lat != 9) begin
      n_fail++; $display("FAIL midcalc_next_word: got calc=%0d err=%0b lat=%0d expected %0d 0 9",
                         calc, e, lat, model_rem(32'hCAFEF00D));
    end
    $display("reset mid-calc: strobes=%0d next calc=%0d", marks, calc);
  endtask

  task automatic test_saturation();
    logic [4:0] calc; logic e; int lat;
    do_clr();
    for (int i = 0; i < 5; i++) begin
      run_word(32'h00000011, 5'd1, calc, e, lat);
      note_err_word(1'b1);
      n_checks++;
      if (int'(err_cnt2) != exp_cnt2 || int'(err_cnt) != exp_cnt) begin
        n_fail++; $display("FAIL saturation[%0d]: got cnt2=%0d cnt=%0d expected %0d %0d",
                           i, err_cnt2, err_cnt, exp_cnt2, exp_cnt);
      end
      $display("saturation word %0d: err_cnt(2b)=%0d err_cnt(16b)=%0d", i, err_cnt2, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 2000;
    logic [4:0] q_calc[$];
    bit         q_err[$];
    int         q_cyc[$];
    int cycle = 0, sent = 0, received = 0, acc_cyc;
    logic [31:0] d; logic [4:0] r, xc; bit xe;
    do_clr();
    while (received < N && cycle < 40000) begin
      if (mark_out) begin
        if (q_calc.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b2b_spurious_mark_out: got strobe at cycle %0d expected none", cycle);
        end else begin
          xc = q_calc.pop_front(); xe = q_err.pop_front(); acc_cyc = q_cyc.pop_front();
          note_err_word(xe);
          n_checks++;
          if (reminder_calc !== xc || err !== xe || (cycle - acc_cyc) != 10 || int'(err_cnt) != exp_cnt) begin
            n_fail++;
            $display("FAIL b2b_word[%0d]: got calc=%0d err=%0b delay=%0d cnt=%0d expected %0d %0b 10 %0d",
                     received, reminder_calc, err, cycle - acc_cyc, err_cnt, xc, xe, exp_cnt);
          end
          received++;
        end
      end
      if (sent < N && ready && $urandom_range(0, 9) != 0) begin
        d = $urandom();
        r = ($urandom_range(0, 1) == 0) ? 5'(model_rem(d)) : 5'($urandom_range(0, 16));
        mark_in = 1'b1; divident = d; reminder_in = r;
        q_calc.push_back(5'(model_rem(d))); q_err.push_back(model_err(d, r)); q_cyc.push_back(cycle);
        sent++;
      end else begin
        mark_in = 1'b0;
      end
      @(posedge clk); #1;
      cycle++;
    end
    mark_in = 1'b0;
    n_checks++;
    if (received != N || overrun !== 1'b0 || int'(err_cnt2) != exp_cnt2) begin
      n_fail++; $display("FAIL b2b_summary: got received=%0d ovr=%0b cnt2=%0d expected %0d 0 %0d",
                         received, overrun, err_cnt2, N, exp_cnt2);
    end
    $display("back-to-back: %0d words in %0d cycles, err_cnt=%0d", received, cycle, err_cnt);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal_rin();
    test_overrun();
    test_reset_mid_calc();
    test_saturation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
